// File: rtl/ex_stage_controller.sv
// -----------------------------------------------------------------------------
// ex_stage_controller
//
// Sequencing controller for the EX stage. Accepts one decoded instruction at
// a time, selects ALU operand 2, performs add/sub in a single cycle or a
// multiply as an iterative shift-add, resolves BEQ (zero, target, next PC) and
// holds the registered result bundle until MEM/WB accepts it.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. in_ready is combinational from state and
// out_ready; out_valid and the whole result bundle are registered and stay
// stable while out_valid=1 && out_ready=0.
//
// Optional build macro:
//   MUL_EARLY_EXIT_EN  - when defined, the multiply stops on the iteration
//                        after which the multiplier has no set bits left.
//                        Results are identical; only latency differs.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   in_valid     in   ID presents an instruction
//   in_ready     out  instruction accepted this cycle (combinational)
//   pc           in   PC of the instruction
//   rs           in   operand 1 (data1)
//   rt           in   register operand 2
//   sign_ext     in   sign-extended immediate
//   alu_src      in   0: data2 = rt, 1: data2 = sign_ext
//   alu_op       in   00 add, 01 sub/beq, 10 R-type, 11 illegal
//   funct        in   R-type: 000000 add, 000001 sub, 000010 mul
//   branch       in   instruction is a branch
//   out_valid    out  result bundle valid
//   out_ready    in   downstream accepts the bundle
//   result       out  ALU result
//   zero         out  data1 == data2
//   branch_taken out  branch && zero
//   pc_out       out  branch target if taken, else pc
//   illegal      out  alu_op 11 or unknown R-type funct
//   busy         out  multiply in progress
//   state_dbg    out  current FSM state (00 IDLE, 01 MUL, 10 DONE)
// -----------------------------------------------------------------------------
module ex_stage_controller #(
    parameter int WIDTH    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] sign_ext,
    input  logic             alu_src,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             branch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic [WIDTH-1:0] pc_out,
    output logic             illegal,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             branch_taken_q, branch_taken_d;
    logic [WIDTH-1:0] pc_out_q, pc_out_d;
    logic             illegal_q, illegal_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // -------------------------------------------------------------------------
    // Operand select and instruction decode (on the live inputs; only used on
    // the accept edge)
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] alu_res;
    logic             is_mul;
    logic             is_ill;
    logic             in_zero;
    logic             in_taken;
    logic [WIDTH-1:0] in_pc_out;

    always_comb begin
        data2   = alu_src ? sign_ext : rt;
        target  = pc + (sign_ext << BR_SHIFT);
        alu_res = '0;
        is_mul  = 1'b0;
        is_ill  = 1'b0;
        case (alu_op)
            2'b00: alu_res = rs + data2;
            2'b01: alu_res = rs - data2;
            2'b10: begin
                case (funct)
                    6'b000000: alu_res = rs + data2;
                    6'b000001: alu_res = rs - data2;
                    6'b000010: is_mul  = 1'b1;
                    default:   is_ill  = 1'b1;
                endcase
            end
            default: is_ill = 1'b1;
        endcase
        // zero is reported for every operation, not only branches
        in_zero   = (rs == data2);
        in_taken  = branch && in_zero;
        in_pc_out = in_taken ? target : pc;
    end

    // -------------------------------------------------------------------------
    // One shift-add multiply step
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mcand_step;
    logic [WIDTH-1:0] mplier_step;
    logic             mul_last;

    always_comb begin
        acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_step  = mcand_q << 1;
        mplier_step = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
        // Once no multiplier bits remain, further iterations add nothing.
        mul_last    = (cnt_q == CW'(WIDTH - 1)) || (mplier_step == '0);
`else
        mul_last    = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    // -------------------------------------------------------------------------
    // FSM next-state and output logic
    // -------------------------------------------------------------------------
    logic accept;

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        result_d       = result_q;
        zero_d         = zero_q;
        branch_taken_d = branch_taken_q;
        pc_out_d       = pc_out_q;
        illegal_d      = illegal_q;
        busy_d         = busy_q;
        acc_d          = acc_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        cnt_d          = cnt_q;

        // DONE can take a new instruction in the same cycle its bundle leaves,
        // which gives one instruction per cycle for single-cycle ops.
        in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        accept   = in_valid && in_ready;

        case (state_q)
            ST_IDLE: ;
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_step;
                mplier_d = mplier_step;
                cnt_d    = cnt_q + CW'(1);
                if (mul_last) begin
                    state_d     = ST_DONE;
                    result_d    = acc_step;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new instruction overrides whatever the state case decided; this
        // covers both IDLE accepts and DONE accepts during a handoff.
        if (accept) begin
            zero_d         = in_zero;
            branch_taken_d = in_taken;
            pc_out_d       = in_pc_out;
            illegal_d      = is_ill;
            if (is_mul) begin
                acc_d       = '0;
                mcand_d     = rs;
                mplier_d    = data2;
                cnt_d       = '0;
                state_d     = ST_MUL;
                busy_d      = 1'b1;
                out_valid_d = 1'b0;
            end else begin
                result_d    = alu_res;
                state_d     = ST_DONE;
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            out_valid_q    <= 1'b0;
            result_q       <= '0;
            zero_q         <= 1'b0;
            branch_taken_q <= 1'b0;
            pc_out_q       <= '0;
            illegal_q      <= 1'b0;
            busy_q         <= 1'b0;
            acc_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            result_q       <= result_d;
            zero_q         <= zero_d;
            branch_taken_q <= branch_taken_d;
            pc_out_q       <= pc_out_d;
            illegal_q      <= illegal_d;
            busy_q         <= busy_d;
            acc_q          <= acc_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            cnt_q          <= cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign branch_taken = branch_taken_q;
    assign pc_out       = pc_out_q;
    assign illegal      = illegal_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ex_stage_controller.sv
// -----------------------------------------------------------------------------
// tb_ex_stage_controller
//
// Directed bench for ex_stage_controller. A transaction-level model predicts
// each bundle from plain arithmetic on accept and the cycle at which it must
// appear; a compare process checks the DUT every cycle against it. Directed
// sections add literal expectations for the listed scenarios.
// -----------------------------------------------------------------------------
module tb_ex_stage_controller;

    localparam int W  = 32;
    localparam int BS = 2;
    localparam int BW = 2 * W + 3;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] pc = '0, rs = '0, rt = '0, sign_ext = '0;
    logic         alu_src = 1'b0;
    logic [1:0]   alu_op = 2'b00;
    logic [5:0]   funct = 6'd0;
    logic         branch = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero, branch_taken;
    logic [W-1:0] pc_out;
    logic         illegal, busy;
    logic [1:0]   state_dbg;

    ex_stage_controller #(.WIDTH(W), .BR_SHIFT(BS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .rs(rs), .rt(rt), .sign_ext(sign_ext),
        .alu_src(alu_src), .alu_op(alu_op), .funct(funct), .branch(branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .branch_taken(branch_taken),
        .pc_out(pc_out), .illegal(illegal), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------------------------------------------------------- counters
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Expected multiply latency in cycles, from data2 alone.
    function automatic int mul_lat(input logic [W-1:0] d2);
        int n;
        n = W;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < W; i++) if (d2[i]) n = i + 1;
`endif
        if (d2 === 'x) n = W;
        return n;
    endfunction

    // Prediction for the instruction on the inputs right now.
    logic [W-1:0]  nx_d2, nx_result, nx_pc_out;
    logic          nx_zero, nx_bt, nx_ill, nx_mul;
    int            nx_lat;

    always_comb begin
        nx_d2     = alu_src ? sign_ext : rt;
        nx_zero   = (rs == nx_d2);
        nx_bt     = branch && nx_zero;
        nx_pc_out = nx_bt ? (pc + (sign_ext << BS)) : pc;
        nx_result = '0;
        nx_ill    = 1'b0;
        nx_mul    = 1'b0;
        if (alu_op == 2'b00)                          nx_result = rs + nx_d2;
        else if (alu_op == 2'b01)                     nx_result = rs - nx_d2;
        else if (alu_op == 2'b10 && funct == 6'd0)    nx_result = rs + nx_d2;
        else if (alu_op == 2'b10 && funct == 6'd1)    nx_result = rs - nx_d2;
        else if (alu_op == 2'b10 && funct == 6'd2) begin
            nx_mul    = 1'b1;
            nx_result = rs * nx_d2;
        end else                                      nx_ill = 1'b1;
        nx_lat = mul_lat(nx_d2);
    end

    // Model state: cycles left on a pending multiply, expected out_valid,
    // and the queue of predicted bundles {illegal, taken, zero, pc_out, result}.
    int            m_mul_left;
    logic          m_ov;
    logic          m_rdy;
    logic          m_acc;
    logic [BW-1:0] exp_q[$];

    always_comb begin
        m_rdy = ((m_mul_left == 0) && !m_ov) || (m_ov && out_ready);
        m_acc = in_valid && m_rdy;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mul_left <= 0;
            m_ov       <= 1'b0;
            exp_q.delete();
        end else begin
            if (m_mul_left > 0) begin
                m_mul_left <= m_mul_left - 1;
                if (m_mul_left == 1) m_ov <= 1'b1;
            end else if (m_ov && out_ready) begin
                m_ov <= 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (m_acc) begin
                exp_q.push_back({nx_ill, nx_bt, nx_zero, nx_pc_out, nx_result});
                if (nx_mul) begin
                    m_mul_left <= nx_lat;
                    m_ov       <= 1'b0;
                end else begin
                    m_ov       <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- compare
    logic [BW-1:0] cmp_b;
    always @(negedge clk) begin
        if (!reset) begin
            check1("rst_out_valid", out_valid, 1'b0);
            check ("rst_result", result, '0);
            check1("rst_busy", busy, 1'b0);
            check ("rst_pc_out", pc_out, '0);
            check1("rst_flags", zero | branch_taken | illegal, 1'b0);
        end else begin
            check1("cyc_in_ready", in_ready, m_rdy);
            check1("cyc_busy", busy, m_mul_left > 0);
            check1("cyc_out_valid", out_valid, m_ov);
            if (m_ov) begin
                if (exp_q.size() == 0) begin
                    check1("cyc_queue_nonempty", 1'b0, 1'b1);
                end else begin
                    cmp_b = exp_q[0];
                    check ("cyc_result", result, cmp_b[W-1:0]);
                    check ("cyc_pc_out", pc_out, cmp_b[2*W-1:W]);
                    check1("cyc_zero", zero, cmp_b[2*W]);
                    check1("cyc_branch_taken", branch_taken, cmp_b[2*W+1]);
                    check1("cyc_illegal", illegal, cmp_b[2*W+2]);
                end
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic set_in(input logic [1:0] op, input logic [5:0] fn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] se, input logic [W-1:0] p,
                          input logic src, input logic br);
        alu_op = op; funct = fn; rs = a; rt = b;
        sign_ext = se; pc = p; alu_src = src; branch = br;
    endtask

    // Present one instruction, wait (bounded) for the handshake, return at
    // accept edge + 1 with data inputs scrambled so later changes are ignored.
    task automatic send(input logic [1:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] se, input logic [W-1:0] p,
                        input logic src, input logic br);
        logic got;
        got = 1'b0;
        set_in(op, fn, a, b, se, p, src, br);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check1("accept_wait", got, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs = $urandom(); rt = $urandom(); sign_ext = $urandom(); pc = $urandom();
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles from now (accept edge + 1) until out_valid rises; -1 on timeout.
    task automatic wait_out(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #200000;
        total++; bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------------------------------------------------------- stimulus
    int lat;
`ifdef MUL_EARLY_EXIT_EN
    localparam int LAT_6X7 = 3;
    localparam int LAT_X0  = 1;
`else
    localparam int LAT_6X7 = 32;
    localparam int LAT_X0  = 32;
`endif

    initial begin
        #1 reset = 1'b0;
        #1;
        check1("reset_out_valid", out_valid, 1'b0);
        check ("reset_result", result, 32'h0);
        check1("reset_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;

        // Add 5+7
        send(2'b10, 6'd0, 32'd5, 32'd7, 32'd0, 32'h0, 1'b0, 1'b0);
        check1("add_out_valid", out_valid, 1'b1);
        check ("add_result", result, 32'd12);
        check1("add_zero", zero, 1'b0);
        check1("add_illegal", illegal, 1'b0);
        idle(2);

        // ADDI with 3 cycles of backpressure
        out_ready = 1'b0;
        send(2'b00, 6'd0, 32'h100, 32'd0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check1("addi_hold_valid", out_valid, 1'b1);
            check ("addi_hold_result", result, 32'h0000_00FC);
            check1("addi_hold_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check1("addi_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        check1("addi_drained", out_valid, 1'b0);
        idle(1);

        // BEQ taken, then not taken (back-to-back through DONE)
        send(2'b01, 6'd0, 32'd9, 32'd9, 32'd3, 32'h100, 1'b0, 1'b1);
        check1("beq_zero", zero, 1'b1);
        check1("beq_taken", branch_taken, 1'b1);
        check ("beq_pc_out", pc_out, 32'h10C);
        send(2'b01, 6'd0, 32'd9, 32'd8, 32'd3, 32'h100, 1'b0, 1'b1);
        check1("beqn_zero", zero, 1'b0);
        check1("beqn_taken", branch_taken, 1'b0);
        check ("beqn_pc_out", pc_out, 32'h100);
        check ("beqn_result", result, 32'd1);
        idle(2);

        // Multiply 6*7
        send(2'b10, 6'd2, 32'd6, 32'd7, 32'd0, 32'h0, 1'b0, 1'b0);
        check1("mul_busy", busy, 1'b1);
        check1("mul_in_ready", in_ready, 1'b0);
        check1("mul_out_valid_low", out_valid, 1'b0);
        wait_out(lat);
        check ("mul_latency", lat, LAT_6X7);
        check ("mul_result", result, 32'd42);
        check1("mul_busy_done", busy, 1'b0);
        idle(2);

        // Multiply by zero (data2 = 0 via immediate)
        send(2'b10, 6'd2, 32'h1234, 32'd99, 32'd0, 32'h0, 1'b1, 1'b0);
        wait_out(lat);
        check ("mulz_latency", lat, LAT_X0);
        check ("mulz_result", result, 32'd0);
        idle(2);

        // Reset during the 10th MUL cycle
        send(2'b10, 6'd2, 32'd3, 32'd5, 32'd0, 32'h40, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check1("rmid_out_valid", out_valid, 1'b0);
        check1("rmid_busy", busy, 1'b0);
        check ("rmid_result", result, 32'd0);
        check ("rmid_pc_out", pc_out, 32'd0);
        check ("rmid_state", {30'd0, state_dbg}, 32'd0);
        check1("rmid_in_ready", in_ready, 1'b1);
        @(negedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;
        send(2'b10, 6'd0, 32'd1, 32'd1, 32'd0, 32'h0, 1'b0, 1'b0);
        check ("post_reset_add", result, 32'd2);
        check1("post_reset_zero", zero, 1'b1);
        idle(2);

        // Back-to-back adds, then illegal, then a multiply taken during handoff
        out_ready = 1'b1;
        set_in(2'b10, 6'd0, 32'd1, 32'd2, 32'd0, 32'h0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check1("b2b1_valid", out_valid, 1'b1);
        check ("b2b1_result", result, 32'd3);
        set_in(2'b00, 6'd0, 32'd10, 32'd0, 32'd20, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check1("b2b2_valid", out_valid, 1'b1);
        check ("b2b2_result", result, 32'd30);
        set_in(2'b10, 6'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check1("b2b3_valid", out_valid, 1'b1);
        check ("b2b3_result", result, 32'd0);
        check1("b2b3_zero", zero, 1'b0);
        set_in(2'b11, 6'd0, 32'd4, 32'd4, 32'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check1("ill_valid", out_valid, 1'b1);
        check ("ill_result", result, 32'd0);
        check1("ill_flag", illegal, 1'b1);
        set_in(2'b10, 6'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check1("hmul_valid_low", out_valid, 1'b0);
        check1("hmul_busy", busy, 1'b1);
        wait_out(lat);
        check ("hmul_latency", lat, 32);
        check ("hmul_result", result, 32'd1);
        idle(2);

        // Unknown funct, and R-type sub with immediate operand
        send(2'b10, 6'd5, 32'd3, 32'd3, 32'd0, 32'h0, 1'b0, 1'b0);
        check1("badfn_illegal", illegal, 1'b1);
        check ("badfn_result", result, 32'd0);
        check1("badfn_zero", zero, 1'b1);
        send(2'b10, 6'd1, 32'd50, 32'd0, 32'd8, 32'h0, 1'b1, 1'b0);
        check ("rsub_result", result, 32'd42);
        check1("rsub_illegal", illegal, 1'b0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
